// File: rtl/div_clk_monitor.sv
// Divided-clock checker: synchronises div_in, measures high/low/period lengths in clk
// cycles and tracks lock/fault against the expected half-period.
module div_clk_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXP_HALF    = 10,
  parameter int TOL         = 1,
  parameter int LOCK_N      = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] low_out,
  output logic [CNT_W-1:0] period_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_N - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_W-1:0]       phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]       high_len_q, high_len_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  logic                   have_high_q, have_high_d;
  logic                   skip_first_q, skip_first_d;
  logic [CNT_W-1:0]       high_out_q, high_out_d;
  logic [CNT_W-1:0]       low_out_q, low_out_d;
  logic [CNT_W-1:0]       period_out_q, period_out_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   locked_q, locked_d;
  logic                   fault_q, fault_d;

  logic             s, rise, fall, edge_det, measure, good, stall;
  logic [CNT_W-1:0] l_len, per_sat;
  logic [CNT_W:0]   per_sum;

  always_comb begin
    s        = sync_q[SYNC_STAGES-1];
    rise     = s & ~s_d_q;
    fall     = ~s & s_d_q;
    edge_det = rise | fall;
    l_len    = (phase_cnt_q == CNT_MAX) ? CNT_MAX : phase_cnt_q + CNT_W'(1);
    good     = (l_len >= LO_LIM) && (l_len <= HI_LIM);
    stall    = (phase_cnt_q == STALL_AT) && !edge_det;
    // the first edge after leaving IDLE closes a partial phase: never measured
    measure  = edge_det && !skip_first_q;
    per_sum  = {1'b0, high_len_q} + {1'b0, l_len};
    per_sat  = per_sum[CNT_W] ? CNT_MAX : per_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], div_in};
    s_d_d        = s;
    phase_cnt_d  = edge_det ? '0 : l_len;
    high_len_d   = high_len_q;
    good_cnt_d   = good_cnt_q;
    have_high_d  = have_high_q;
    skip_first_d = skip_first_q;
    high_out_d   = high_out_q;
    low_out_d    = low_out_q;
    period_out_d = period_out_q;
    meas_valid_d = 1'b0;

    if (state_q == IDLE) begin
      phase_cnt_d  = '0;
      good_cnt_d   = '0;
      have_high_d  = 1'b0;
      skip_first_d = 1'b1;
      if (en) state_d = ACQUIRE;
    end else begin
      if (edge_det) skip_first_d = 1'b0;
      if (measure && fall) begin
        high_len_d  = l_len;
        have_high_d = 1'b1;
      end
      if (measure && rise && have_high_q) begin
        high_out_d   = high_len_q;
        low_out_d    = l_len;
        period_out_d = per_sat;
        meas_valid_d = 1'b1;
        have_high_d  = 1'b0;
      end
      case (state_q)
        ACQUIRE: begin
          if (measure) begin
            if (!good) good_cnt_d = '0;
            else if (good_cnt_q == LAST_GOOD) begin
              good_cnt_d = '0;
              state_d    = LOCKED;
            end else good_cnt_d = good_cnt_q + GW'(1);
          end else if (stall) good_cnt_d = '0;
        end
        LOCKED: if ((measure && !good) || stall) state_d = FAULT;
        default: ;
      endcase
      // disable wins over any edge seen in the same cycle
      if (!en) begin
        state_d      = IDLE;
        phase_cnt_d  = '0;
        good_cnt_d   = '0;
        have_high_d  = 1'b0;
        skip_first_d = 1'b1;
        meas_valid_d = 1'b0;
        high_out_d   = high_out_q;
        low_out_d    = low_out_q;
        period_out_d = period_out_q;
      end
    end

    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      phase_cnt_q  <= '0;
      high_len_q   <= '0;
      good_cnt_q   <= '0;
      have_high_q  <= 1'b0;
      skip_first_q <= 1'b0;
      high_out_q   <= '0;
      low_out_q    <= '0;
      period_out_q <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_d_q        <= s_d_d;
      phase_cnt_q  <= phase_cnt_d;
      high_len_q   <= high_len_d;
      good_cnt_q   <= good_cnt_d;
      have_high_q  <= have_high_d;
      skip_first_q <= skip_first_d;
      high_out_q   <= high_out_d;
      low_out_q    <= low_out_d;
      period_out_q <= period_out_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  assign high_out   = high_out_q;
  assign low_out    = low_out_q;
  assign period_out = period_out_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: half-period tables plus glitch, stall,
// disable and reset sequences with hand-computed expectations.
module tb_div_clk_monitor;

  logic        clk = 1'b0;
  logic        rst, en, div_in;
  logic [15:0] high_out, low_out, period_out;
  logic        meas_valid, locked, fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int len;  // clk cycles since the previous div_in toggle
    int lk;
    int ft;
    int mv;
    int hi;
    int lo;
    int per;
  } vec_t;

  vec_t tab1[8];
  vec_t tab2[4];
  vec_t tab3[4];

  div_clk_monitor dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in),
    .high_out(high_out), .low_out(low_out), .period_out(period_out),
    .meas_valid(meas_valid), .locked(locked), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Toggle div_in v.len cycles after the previous toggle, then look at the
  // registered result of that edge (sync + edge-detect + register = 3 cycles).
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    repeat (v.len - 3) step();
    div_in = ~div_in;
    repeat (3) step();
    chk($sformatf("%s[%0d].locked", tag, idx), int'(locked), v.lk);
    chk($sformatf("%s[%0d].fault", tag, idx), int'(fault), v.ft);
    chk($sformatf("%s[%0d].meas_valid", tag, idx), int'(meas_valid), v.mv);
    if (v.mv != 0) begin
      chk($sformatf("%s[%0d].high_out", tag, idx), int'(high_out), v.hi);
      chk($sformatf("%s[%0d].low_out", tag, idx), int'(low_out), v.lo);
      chk($sformatf("%s[%0d].period_out", tag, idx), int'(period_out), v.per);
    end
  endtask

  initial begin
    tab1 = '{'{10, 0, 0, 0,  0,  0,  0},
             '{10, 0, 0, 1, 10, 10, 20},
             '{10, 0, 0, 0,  0,  0,  0},
             '{10, 1, 0, 1, 10, 10, 20},
             '{10, 1, 0, 0,  0,  0,  0},
             '{11, 1, 0, 1, 10, 11, 21},
             '{12, 0, 1, 0,  0,  0,  0},
             '{10, 0, 1, 1, 12, 10, 22}};
    tab2 = '{'{10, 0, 0, 0,  0,  0,  0},
             '{10, 0, 0, 0,  0,  0,  0},
             '{10, 0, 0, 1, 10, 10, 20},
             '{10, 1, 0, 0,  0,  0,  0}};
    tab3 = '{'{10, 0, 0, 1,  1, 10, 11},
             '{10, 0, 0, 0,  0,  0,  0},
             '{10, 0, 0, 1, 10, 10, 20},
             '{10, 1, 0, 0,  0,  0,  0}};

    rst = 1'b1; en = 1'b0; div_in = 1'b0;
    repeat (2) step();
    chk("reset.locked", int'(locked), 0);
    chk("reset.fault", int'(fault), 0);
    chk("reset.meas_valid", int'(meas_valid), 0);
    chk("reset.period_out", int'(period_out), 0);
    rst = 1'b0; en = 1'b1;
    repeat (2) step();

    // Acquire and lock at 10/10, stretch to 11 (still locked), 12 faults
    div_in = ~div_in;  // partial first phase, ignored
    repeat (3) step();
    foreach (tab1[i]) run_vec("lock", i, tab1[i]);

    // Drop enable for one cycle: fault clears, outputs hold
    en = 1'b0;
    step();
    chk("idle.fault", int'(fault), 0);
    chk("idle.locked", int'(locked), 0);
    chk("idle.meas_valid", int'(meas_valid), 0);
    chk("idle.period_hold", int'(period_out), 22);
    en = 1'b1;
    step();
    div_in = ~div_in;  // first edge after re-enable, ignored
    repeat (3) step();
    foreach (tab2[i]) run_vec("relock", i, tab2[i]);

    // Stall while locked: fault one cycle after phase_cnt hits TIMEOUT-1
    repeat (63) step();
    chk("stall.pre_fault", int'(fault), 0);
    chk("stall.pre_locked", int'(locked), 1);
    step();
    chk("stall.fault", int'(fault), 1);
    chk("stall.locked", int'(locked), 0);

    // Glitch during acquire resets the good count
    en = 1'b0; div_in = 1'b0;
    repeat (5) step();
    en = 1'b1;
    step();
    div_in = ~div_in;
    repeat (3) step();
    run_vec("pre_glitch", 0, '{10, 0, 0, 0, 0, 0, 0});
    repeat (7) step();
    div_in = ~div_in;
    step();
    div_in = ~div_in;
    repeat (3) step();
    chk("glitch.locked", int'(locked), 0);
    chk("glitch.fault", int'(fault), 0);
    foreach (tab3[i]) run_vec("post_glitch", i, tab3[i]);

    // Reset lands on the cycle a measuring rise is being detected
    repeat (7) step();
    div_in = ~div_in;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("midrst.locked", int'(locked), 0);
    chk("midrst.fault", int'(fault), 0);
    chk("midrst.meas_valid", int'(meas_valid), 0);
    chk("midrst.high_out", int'(high_out), 0);
    chk("midrst.low_out", int'(low_out), 0);
    chk("midrst.period_out", int'(period_out), 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
